// File: rtl/lvds_frame_tx_if.sv
// Handshake and line-side bundle of the LVDS transmit framer.
// Latency: none, wires only.
// Backpressure: i_ready is driven by the framer and qualifies i_valid.
interface lvds_frame_tx_if #(
   parameter int W     = 66,
   parameter int LANES = 4,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             i_valid;
   logic [W-1:0]     i_data;
   logic             i_ready;
   logic [LANES-1:0] o_data;
   logic             o_busy;
   logic [LW-1:0]    o_level;

   modport master (output i_valid, i_data, input i_ready, o_data, o_busy, o_level);
   modport slave  (input i_valid, i_data, output i_ready, o_data, o_busy, o_level);
endinterface

// File: rtl/lvds_frame_tx.sv
// Transmit framer: FIFO-buffered W-bit words -> start bit, data MSB first, optional parity, 1s pad, LANES bits per cycle.
// Latency: word pushed at edge k into an idle, empty framer drives its first lane-word after edge k+1.
// Backpressure: i_ready = rn && level < DEPTH from registered state; frames are separated by GAP+1 idle lane-words.
module lvds_frame_tx #(
   parameter int W      = 66,
   parameter int LANES  = 4,
   parameter int DEPTH  = 4,
   parameter int PARITY = 1,
   parameter int GAP    = 0
) (
   input  logic           c,
   input  logic           rn,
   input  logic           inv,
   lvds_frame_tx_if.slave io_tx
);
   localparam int F  = 1 + W + PARITY;          // start + data + parity bits
   localparam int N  = (F + LANES - 1) / LANES; // lane-words per frame
   localparam int SW = N * LANES;               // padded frame width
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(N + 1);

   // Reject parameter sets the framer cannot be built for.
   generate
      if (W < 1 || W > 128) begin : g_bad_w
         $error("lvds_frame_tx: W must be 1..128");
      end
      if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
         $error("lvds_frame_tx: LANES must be 1, 2, 4 or 8");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("lvds_frame_tx: DEPTH must be a power of two >= 2");
      end
      if (PARITY != 0 && PARITY != 1) begin : g_bad_parity
         $error("lvds_frame_tx: PARITY must be 0 or 1");
      end
      if (GAP < 0 || GAP > 15) begin : g_bad_gap
         $error("lvds_frame_tx: GAP must be 0..15");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   logic [W-1:0]     r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [LW-1:0]    r_level;
   state_t           r_state;
   state_t           w_state_nx;
   logic [BW-1:0]    r_beat;
   logic [BW-1:0]    w_beat_nx;
   logic [4:0]       r_gap;
   logic [4:0]       w_gap_nx;
   logic [SW-1:0]    r_sh;
   logic [SW-1:0]    w_sh_nx;
   logic [LANES-1:0] r_dat;
   logic [LANES-1:0] w_dat_nx;
   logic             r_busy;
   logic             w_ready;
   logic             w_push;
   logic             w_pop;
   logic [LW-1:0]    w_level_nx;
   logic [W-1:0]     w_head;
   logic [F-1:0]     w_bits;
   logic [SW-1:0]    w_frame;
   logic [LANES-1:0] w_inv;

   assign w_ready    = rn && (r_level < LW'(DEPTH));
   assign w_push     = io_tx.i_valid && w_ready;
   assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
   assign w_level_nx = r_level + LW'(w_push) - LW'(w_pop);
   assign w_head     = r_mem[r_rp];
   assign w_inv      = {LANES{inv}};

   generate
      if (PARITY != 0) begin : g_par
         assign w_bits = {1'b0, w_head, ^w_head};
      end else begin : g_nopar
         assign w_bits = {1'b0, w_head};
      end
   endgenerate

   // Frame bits in the top F positions, low pad bits forced to 1 (idle level).
   assign w_frame = ~(SW'(~w_bits) << (SW - F));

   // Next-state and next lane-word: pop into the shifter, stream N beats, then GAP+1 idle beats.
   always_comb begin
      w_state_nx = r_state;
      w_beat_nx  = r_beat;
      w_gap_nx   = r_gap;
      w_sh_nx    = r_sh;
      w_dat_nx   = {LANES{1'b1}} ^ w_inv;
      case (r_state)
         S_IDLE: begin
            if (w_pop) begin
               w_dat_nx = w_frame[SW-1 -: LANES] ^ w_inv;
               w_sh_nx  = w_frame << LANES;
               if (N > 1) begin
                  w_state_nx = S_SEND;
                  w_beat_nx  = BW'(N - 1);
               end else begin
                  w_state_nx = S_GAP;
                  w_gap_nx   = 5'(GAP + 1);
               end
            end
         end
         S_SEND: begin
            w_dat_nx  = r_sh[SW-1 -: LANES] ^ w_inv;
            w_sh_nx   = r_sh << LANES;
            w_beat_nx = r_beat - BW'(1);
            if (r_beat == BW'(1)) begin
               w_state_nx = S_GAP;
               w_gap_nx   = 5'(GAP + 1);
            end
         end
         S_GAP: begin
            w_gap_nx = r_gap - 5'd1;
            if (r_gap == 5'd1) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // FSM, shifter, line register and busy flag; reset parks the line at idle without inversion.
   always_ff @(posedge c) begin
      if (!rn) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_gap   <= '0;
         r_sh    <= '1;
         r_dat   <= '1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_beat  <= w_beat_nx;
         r_gap   <= w_gap_nx;
         r_sh    <= w_sh_nx;
         r_dat   <= w_dat_nx;
         r_busy  <= (w_state_nx != S_IDLE) || (w_level_nx != '0);
      end
   end

   // FIFO pointers and occupancy; a same-edge push and pop leaves the level unchanged.
   always_ff @(posedge c) begin
      if (!rn) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wp <= r_wp + AW'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + AW'(1);
         end
         r_level <= w_level_nx;
      end
   end

   // FIFO storage; contents are don't-care until the level covers them.
   always_ff @(posedge c) begin
      if (w_push) begin
         r_mem[r_wp] <= io_tx.i_data;
      end
   end

   assign io_tx.i_ready = w_ready;
   assign io_tx.o_data  = r_dat;
   assign io_tx.o_busy  = r_busy;
   assign io_tx.o_level = r_level;
endmodule

// File: tb/tb_lvds_frame_tx.sv
// Bench for lvds_frame_tx: three configurations against a frame-level reference model.
// Latency: model predicts line, level, busy and ready every cycle.
// Backpressure: valid held against a full FIFO; only accepted words enter the model.
module tb_lvds_frame_tx;
   localparam int NDUT = 3;

   logic c = 1'b0;
   logic rn;
   logic inv;
   logic         vld  [NDUT];
   logic [127:0] din  [NDUT];
   logic         rdy  [NDUT];
   logic         busy [NDUT];
   logic [7:0]   dout [NDUT];
   logic [7:0]   lvl  [NDUT];

   // reference model state
   logic [127:0] mf    [NDUT][8];
   int           mcnt  [NDUT];
   logic [7:0]   ml    [NDUT][64];
   int           mlen  [NDUT];
   logic [7:0]   mout  [NDUT];
   logic         mbusy [NDUT];

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] e_a5  [4]  = '{8'h5, 8'h2, 8'hB, 8'hF};
   logic [7:0] e_a5i [4]  = '{8'hA, 8'hD, 8'h4, 8'h0};
   logic [7:0] e_b0  [9]  = '{8'h0, 8'h0, 8'h3, 8'hF, 8'h0, 8'h0, 8'h3, 8'hF, 8'hF};
   logic [7:0] e_b2  [15] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h3, 8'h3, 8'h3,
                             8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h3, 8'h3};

   always #5 c = ~c;

   lvds_frame_tx_if #(.W(8),  .LANES(4), .DEPTH(4)) if0 ();
   lvds_frame_tx_if #(.W(66), .LANES(4), .DEPTH(4)) if1 ();
   lvds_frame_tx_if #(.W(8),  .LANES(2), .DEPTH(2)) if2 ();

   lvds_frame_tx #(.W(8),  .LANES(4), .DEPTH(4), .PARITY(1), .GAP(0))
      u_dut0 (.c(c), .rn(rn), .inv(inv), .io_tx(if0));
   lvds_frame_tx #(.W(66), .LANES(4), .DEPTH(4), .PARITY(1), .GAP(0))
      u_dut1 (.c(c), .rn(rn), .inv(inv), .io_tx(if1));
   lvds_frame_tx #(.W(8),  .LANES(2), .DEPTH(2), .PARITY(0), .GAP(2))
      u_dut2 (.c(c), .rn(rn), .inv(inv), .io_tx(if2));

   assign if0.i_valid = vld[0];
   assign if0.i_data  = din[0][7:0];
   assign if1.i_valid = vld[1];
   assign if1.i_data  = din[1][65:0];
   assign if2.i_valid = vld[2];
   assign if2.i_data  = din[2][7:0];

   assign rdy[0]  = if0.i_ready;
   assign rdy[1]  = if1.i_ready;
   assign rdy[2]  = if2.i_ready;
   assign busy[0] = if0.o_busy;
   assign busy[1] = if1.o_busy;
   assign busy[2] = if2.o_busy;
   assign dout[0] = 8'(if0.o_data);
   assign dout[1] = 8'(if1.o_data);
   assign dout[2] = 8'(if2.o_data);
   assign lvl[0]  = 8'(if0.o_level);
   assign lvl[1]  = 8'(if1.o_level);
   assign lvl[2]  = 8'(if2.o_level);

   function automatic int p_w(int d); return (d == 1) ? 66 : 8; endfunction
   function automatic int p_l(int d); return (d == 2) ? 2 : 4;  endfunction
   function automatic int p_d(int d); return (d == 2) ? 2 : 4;  endfunction
   function automatic int p_p(int d); return (d == 2) ? 0 : 1;  endfunction
   function automatic int p_g(int d); return (d == 2) ? 2 : 0;  endfunction

   function automatic logic [7:0] lmask(int d);
      return 8'((1 << p_l(d)) - 1);
   endfunction

   function automatic int nwords(int d);
      return (1 + p_w(d) + p_p(d) + p_l(d) - 1) / p_l(d);
   endfunction

   // bit b of the serial frame: 0 = start, 1..W = data MSB first, then parity, then 1s
   function automatic logic frame_bit(logic [127:0] data, int d, int b);
      int ones = 0;
      if (b == 0) return 1'b0;
      if (b <= p_w(d)) return data[p_w(d) - b];
      if (p_p(d) != 0 && b == p_w(d) + 1) begin
         for (int i = 0; i < p_w(d); i++) ones += int'(data[i]);
         return 1'((ones % 2) != 0);
      end
      return 1'b1;
   endfunction

   // lane-word j: earliest serial bit in the MSB lane
   function automatic logic [7:0] lane_word(logic [127:0] data, int d, int j);
      logic [7:0] r = '0;
      for (int k = 0; k < p_l(d); k++) r[p_l(d) - 1 - k] = frame_bit(data, d, j * p_l(d) + k);
      return r;
   endfunction

   function automatic logic [127:0] rnd_word(int d);
      logic [127:0] r = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int b = p_w(d); b < 128; b++) r[b] = 1'b0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   // One clock edge of the reference: a frame (plus GAP+1 idle beats) is queued on the line
   // whenever the line is empty and words wait; the push lands behind the pop.
   task automatic model_step();
      for (int d = 0; d < NDUT; d++) begin
         logic [7:0] w;
         logic       acc;
         if (!rn) begin
            mcnt[d]  = 0;
            mlen[d]  = 0;
            mout[d]  = lmask(d);
            mbusy[d] = 1'b0;
         end else begin
            acc = vld[d] && (mcnt[d] < p_d(d));
            if (mlen[d] == 0 && mcnt[d] > 0) begin
               for (int j = 0; j < nwords(d); j++) ml[d][j] = lane_word(mf[d][0], d, j);
               for (int g = 0; g <= p_g(d); g++) ml[d][nwords(d) + g] = lmask(d);
               mlen[d] = nwords(d) + p_g(d) + 1;
               for (int i = 1; i < mcnt[d]; i++) mf[d][i - 1] = mf[d][i];
               mcnt[d]--;
            end
            if (mlen[d] > 0) begin
               w = ml[d][0];
               for (int i = 1; i < mlen[d]; i++) ml[d][i - 1] = ml[d][i];
               mlen[d]--;
            end else begin
               w = lmask(d);
            end
            mout[d] = w ^ (inv ? lmask(d) : 8'h00);
            if (acc) begin
               mf[d][mcnt[d]] = din[d];
               mcnt[d]++;
            end
            mbusy[d] = (mlen[d] > 0) || (mcnt[d] > 0);
         end
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("dut%0d o_data", d),  128'(dout[d]), 128'(mout[d]));
         chk($sformatf("dut%0d o_level", d), 128'(lvl[d]),  128'(mcnt[d]));
         chk($sformatf("dut%0d o_busy", d),  128'(busy[d]), 128'(mbusy[d]));
         chk($sformatf("dut%0d i_ready", d), 128'(rdy[d]),  128'(rn && (mcnt[d] < p_d(d))));
      end
   endtask

   task automatic cycle();
      @(posedge c);
      model_step();
      @(negedge c);
      check_all();
   endtask

   initial begin
      int cnt [NDUT];
      int maxl [NDUT];
      logic was_rdy [NDUT];
      rn  = 1'b0;
      inv = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         vld[d] = 1'b0;
         din[d] = '0;
      end
      repeat (3) cycle();
      chk("rst o_data d0", 128'(dout[0]), 128'h0F);
      chk("rst o_data d2", 128'(dout[2]), 128'h03);
      chk("rst i_ready", 128'(rdy[0]), 128'h0);
      chk("rst o_busy", 128'(busy[1]), 128'h0);
      chk("rst o_level", 128'(lvl[2]), 128'h0);
      rn = 1'b1;
      cycle();
      chk("idle i_ready", 128'(rdy[0]), 128'h1);

      // single 0xA5 frame, line not inverted
      vld[0] = 1'b1; din[0] = 128'hA5;
      cycle();
      vld[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("a5 word%0d", i), 128'(dout[0]), 128'(e_a5[i]));
      end

      // same frame with the line inverted from the first lane-word on
      vld[0] = 1'b1; din[0] = 128'hA5;
      cycle();
      vld[0] = 1'b0; inv = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("a5 inv word%0d", i), 128'(dout[0]), 128'(e_a5i[i]));
      end
      inv = 1'b0;
      repeat (2) cycle();

      // 66-bit zero word: 68 frame bits fill 17 lane-words exactly, so no padding
      vld[1] = 1'b1; din[1] = '0;
      cycle();
      vld[1] = 1'b0;
      for (int i = 0; i < 17; i++) begin
         cycle();
         chk($sformatf("w66 word%0d", i), 128'(dout[1]), 128'h0);
      end
      cycle();
      chk("w66 idle", 128'(dout[1]), 128'hF);
      repeat (2) cycle();

      // two back-to-back words: push+pop at level 1, then inter-frame gaps
      vld[0] = 1'b1; din[0] = '0;
      vld[2] = 1'b1; din[2] = '0;
      cycle();
      chk("b2b level d0", 128'(lvl[0]), 128'h1);
      cycle();
      vld[0] = 1'b0; vld[2] = 1'b0;
      chk("pushpop level d0", 128'(lvl[0]), 128'h1);
      chk("pushpop level d2", 128'(lvl[2]), 128'h1);
      for (int i = 0; i < 15; i++) begin
         if (i > 0) cycle();
         chk($sformatf("gap d2 word%0d", i), 128'(dout[2]), 128'(e_b2[i]));
         if (i < 9) chk($sformatf("gap d0 word%0d", i), 128'(dout[0]), 128'(e_b0[i]));
      end
      repeat (4) cycle();

      // back-pressure: valid held with an incrementing payload
      for (int d = 0; d < NDUT; d++) begin
         cnt[d]  = 1;
         maxl[d] = 0;
      end
      for (int n = 0; n < 60; n++) begin
         for (int d = 0; d < NDUT; d++) begin
            vld[d]     = 1'b1;
            din[d]     = 128'(cnt[d]);
            was_rdy[d] = rdy[d];
         end
         cycle();
         for (int d = 0; d < NDUT; d++) begin
            if (was_rdy[d]) cnt[d]++;
            if (int'(lvl[d]) > maxl[d]) maxl[d] = int'(lvl[d]);
         end
      end
      for (int d = 0; d < NDUT; d++) vld[d] = 1'b0;
      chk("bp max level d0", 128'(maxl[0]), 128'd4);
      chk("bp max level d1", 128'(maxl[1]), 128'd4);
      chk("bp max level d2", 128'(maxl[2]), 128'd2);
      repeat (120) cycle();

      // reset mid-frame with three 66-bit words still queued
      vld[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din[1] = rnd_word(1);
         cycle();
      end
      vld[1] = 1'b0;
      chk("pre-rst level d1", 128'(lvl[1]), 128'd3);
      rn = 1'b0;
      cycle();
      chk("midrst o_data", 128'(dout[1]), 128'hF);
      chk("midrst o_level", 128'(lvl[1]), 128'h0);
      chk("midrst o_busy", 128'(busy[1]), 128'h0);
      chk("midrst i_ready", 128'(rdy[1]), 128'h0);
      rn = 1'b1;
      cycle();
      chk("post-rst i_ready", 128'(rdy[1]), 128'h1);
      vld[0] = 1'b1; din[0] = 128'hA5;
      cycle();
      vld[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("post-rst a5 word%0d", i), 128'(dout[0]), 128'(e_a5[i]));
      end

      // randomized traffic, inversion toggles and occasional resets
      for (int n = 0; n < 3000; n++) begin
         int pct;
         pct = ((n / 500) % 2 == 0) ? 30 : 90;
         for (int d = 0; d < NDUT; d++) begin
            vld[d] = ($urandom_range(0, 99) < pct);
            din[d] = rnd_word(d);
         end
         if ($urandom_range(0, 9) == 0) inv = ~inv;
         rn = ($urandom_range(0, 399) != 0);
         cycle();
      end
      rn  = 1'b1;
      inv = 1'b0;
      for (int d = 0; d < NDUT; d++) vld[d] = 1'b0;
      repeat (150) cycle();
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("drained busy d%0d", d), 128'(busy[d]), 128'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
